imem_boot_rom: RTL and testbench
================================

Name: imem_boot_rom

Overview:
- Parametrised instruction memory that replaces the fixed hard-coded program store feeding the single-cycle core's fetch stage.
- After reset, a valid/ready boot-load stream fills the memory sequentially from word 0. The fetch port then serves instructions by byte address.
- Fetch flags misaligned and out-of-range addresses and substitutes a NOP for them.
- Sits between the boot source (testbench/UART loader) and the PC/fetch logic of the rv32im core.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of words; must be ≥2. Index width IDX_W = $clog2(DEPTH).
- ADDR_W, 32, fetch byte-address width.
- NOP_WORD, 32'h00000013, word returned when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_valid_i  in  1  boot word present.
- load_ready_o  out  1  block accepts a boot word.
- load_data_i  in  DATA_W  boot word.
- load_last_i  in  1  marks the final boot word; qualified by valid&ready.
- boot_done_o  out  1  program loaded; fetch enabled.
- word_count_o  out  IDX_W+1  number of loaded words.
- fetch_addr_i  in  ADDR_W  byte address from PC.
- fetch_data_o  out  DATA_W  instruction word.
- fetch_misalign_o  out  1  fetch_addr_i[1:0] != 0.
- fetch_oob_o  out  1  word index ≥ word_count_o.

Behaviour:
- Reset is synchronous, active-low, sampled on the rising edge of clk: rst_n=0 at a rising edge resets the block.
- Reset values:
  - state=LOAD, load_ready_o=1, boot_done_o=0, word_count_o=0, write pointer=0.
  - fetch_data_o=NOP_WORD, both fault flags 0.
  - Memory array is not cleared.
- States: LOAD, RUN.
- LOAD:
  - load_ready_o=1.
  - On load_valid_i&load_ready_o: mem[ptr]<=load_data_i; ptr<=ptr+1; word_count_o<=ptr+1.
  - If the accepted beat has load_last_i=1, or ptr==DEPTH-1: next state RUN.
  - Entering RUN sets boot_done_o=1 and load_ready_o=0 in the following cycle.
  - A DEPTH-th word with load_last_i=0 still terminates the load; there is no wrap-around and no overwrite.
- RUN:
  - load_ready_o=0; load_valid_i is ignored and the memory is unchanged.
  - Only reset returns the block to LOAD.
- Reset mid-load: ptr and word_count_o return to 0. Earlier words remain in the array but are unreachable until reloaded, because the out-of-range check uses word_count_o.
- Fetch, combinational from fetch_addr_i and current state:
  - Word index = fetch_addr_i >> 2, compared against word_count_o using the full address width. Upper bits are never truncated, so an aliased address is still out of range.
  - boot_done_o=0: data=NOP_WORD, both flags 0.
  - Misaligned (addr[1:0]!=0): fetch_misalign_o=1, fetch_oob_o=0, data=NOP_WORD. Misalign has priority over out-of-range.
  - Aligned and index ≥ word_count_o: fetch_oob_o=1, data=NOP_WORD.
  - Otherwise: data=mem[index], both flags 0.
- The word loaded in the final LOAD cycle is fetchable from the first RUN cycle.

Optional Feature:
- Macro: IMEM_FETCH_REG_EN.
- Defined:
  - fetch_data_o, fetch_misalign_o and fetch_oob_o are registered: a response appears one clk after fetch_addr_i is sampled.
  - The registers reset to NOP_WORD/0/0 and load NOP_WORD/0/0 while boot_done_o=0.
- Undefined:
  - Combinational read with zero latency; this matches the current single-cycle core.

Test Plan:
- Reset, then stream 0x00100093, 0x00200113, 0x002081B3 with last on the third word → boot_done_o=1 next cycle; word_count_o=3; fetch 0x0/0x4/0x8 returns those words with no flags.
- After the load above, fetch 0xC → fetch_oob_o=1, data=0x00000013. Fetch 0x1_0000_0000-wrapped alias 0x0000_0104 with DEPTH=64 → oob=1.
- Fetch 0x6 → fetch_misalign_o=1, oob=0, data=0x00000013. Fetch 0xE → misalign=1, oob=0 (priority).
- Stream DEPTH words with load_last_i=0 throughout → after word 64, load_ready_o=0 and word_count_o=64. A 65th valid beat is not accepted, and mem[0] is unchanged.
- Load 2 words, assert rst_n=0 for one cycle, then load 1 word with last → word_count_o=1; fetch 0x4 gives oob=1 despite stale data.
- Fetch while in LOAD with valid addresses → data=NOP_WORD, flags 0. With IMEM_FETCH_REG_EN defined, repeat the first scenario and check a 1-cycle response latency.

Source files
------------

// File: rtl/imem_boot_rom.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_rom
// Purpose  : Boot-loaded instruction memory; a valid/ready stream fills it,
//            then byte-addressed fetch with misalign/out-of-range NOP substitution.
//            Define IMEM_FETCH_REG_EN to register the fetch response (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_rom #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013,
  localparam int               IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              boot_done_o,
  output logic [IDX_W:0]    word_count_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_data_o,
  output logic              fetch_misalign_o,
  output logic              fetch_oob_o
);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W:0]    r_count;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_accept;
  logic              w_ready;
  logic              w_done;

  assign w_accept = rst_n & load_valid_i & w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= {1'b0, r_ptr} + (IDX_W+1)'(1);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ready = 1'b1;
        // The last slot closes the load even without load_last_i: no wrap-around.
        if (w_accept && (load_last_i || (r_ptr == IDX_W'(DEPTH-1))))
          w_next = S_RUN;
      end
      S_RUN: begin
        w_done = 1'b1;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // Array is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[r_ptr] <= load_data_i;
  end

  assign load_ready_o = w_ready;
  assign boot_done_o  = w_done;
  assign word_count_o = r_count;

  // Full-width index compare so high address bits can never alias into range.
  logic [ADDR_W-1:0] w_idx;
  logic              w_mis_raw;
  logic              w_oob_raw;
  logic [DATA_W-1:0] w_fdata;
  logic              w_fmis;
  logic              w_foob;

  assign w_idx     = {2'b00, fetch_addr_i[ADDR_W-1:2]};
  assign w_mis_raw = |fetch_addr_i[1:0];
  assign w_oob_raw = (w_idx >= ADDR_W'(r_count));

  always_comb begin
    w_fdata = NOP_WORD;
    w_fmis  = 1'b0;
    w_foob  = 1'b0;
    if (w_done) begin
      if (w_mis_raw)
        w_fmis = 1'b1;
      else if (w_oob_raw)
        w_foob = 1'b1;
      else
        w_fdata = r_mem[w_idx[IDX_W-1:0]];
    end
  end

`ifdef IMEM_FETCH_REG_EN
  logic [DATA_W-1:0] r_fdata;
  logic              r_fmis;
  logic              r_foob;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fdata <= NOP_WORD;
      r_fmis  <= 1'b0;
      r_foob  <= 1'b0;
    end else begin
      r_fdata <= w_fdata;
      r_fmis  <= w_fmis;
      r_foob  <= w_foob;
    end
  end

  assign fetch_data_o     = r_fdata;
  assign fetch_misalign_o = r_fmis;
  assign fetch_oob_o      = r_foob;
`else
  assign fetch_data_o     = w_fdata;
  assign fetch_misalign_o = w_fmis;
  assign fetch_oob_o      = w_foob;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_rom
// Purpose  : Directed self-checking bench for imem_boot_rom with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_rom;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [31:0] load_data_i = '0;
  logic        load_last_i = 1'b0;
  logic        boot_done_o;
  logic [6:0]  word_count_o;
  logic [31:0] fetch_addr_i = '0;
  logic [31:0] fetch_data_o;
  logic        fetch_misalign_o;
  logic        fetch_oob_o;

  imem_boot_rom dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_valid_i     (load_valid_i),
    .load_ready_o     (load_ready_o),
    .load_data_i      (load_data_i),
    .load_last_i      (load_last_i),
    .boot_done_o      (boot_done_o),
    .word_count_o     (word_count_o),
    .fetch_addr_i     (fetch_addr_i),
    .fetch_data_o     (fetch_data_o),
    .fetch_misalign_o (fetch_misalign_o),
    .fetch_oob_o      (fetch_oob_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: loaded words, how many, and whether loading has finished.
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_count <= 0;
      m_done  <= 1'b0;
    end else if (!m_done && load_valid_i) begin
      m_mem[m_count] <= load_data_i;
      m_count        <= m_count + 1;
      m_done         <= load_last_i || (m_count + 1 == DEPTH);
    end
  end

  function automatic void model_fetch(input logic [31:0] a, output logic [31:0] d,
                                      output logic mis, output logic oob);
    logic [31:0] idx;
    idx = a / 4;
    d = NOP; mis = 1'b0; oob = 1'b0;
    if (m_done) begin
      if (a % 4 != 0) mis = 1'b1;
      else if (idx >= 32'(m_count)) oob = 1'b1;
      else d = m_mem[idx];
    end
  endfunction

  logic [31:0] e_data;
  logic        e_mis, e_oob;
`ifdef IMEM_FETCH_REG_EN
  always @(posedge clk) begin
    logic [31:0] d; logic mi, oo;
    model_fetch(fetch_addr_i, d, mi, oo);
    if (!rst_n) begin
      e_data <= NOP; e_mis <= 1'b0; e_oob <= 1'b0;
    end else begin
      e_data <= d; e_mis <= mi; e_oob <= oo;
    end
  end
`else
  always_comb model_fetch(fetch_addr_i, e_data, e_mis, e_oob);
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model ready", 32'(load_ready_o), 32'(!m_done));
      chk("model done",  32'(boot_done_o),  32'(m_done));
      chk("model count", 32'(word_count_o), 32'(m_count));
      chk("model data",  fetch_data_o,      e_data);
      chk("model mis",   32'(fetch_misalign_o), 32'(e_mis));
      chk("model oob",   32'(fetch_oob_o),  32'(e_oob));
    end
  end

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    load_valid_i = 1'b1; load_data_i = d; load_last_i = last;
    @(posedge clk);
    #2 load_valid_i = 1'b0; load_last_i = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] d,
                       input logic mis, input logic oob);
    fetch_addr_i = a;
`ifdef IMEM_FETCH_REG_EN
    @(negedge clk);
    chk({name, " pre-latency"}, 32'(fetch_addr_i == a), 32'd1);
    @(posedge clk); #2;
`endif
    @(negedge clk);
    chk({name, " data"}, fetch_data_o, d);
    chk({name, " mis"},  32'(fetch_misalign_o), 32'(mis));
    chk({name, " oob"},  32'(fetch_oob_o), 32'(oob));
    @(posedge clk); #2;
  endtask

  initial begin
    @(posedge clk); #2;
    do_reset(2);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(load_ready_o), 32'd1);
    chk("reset done",  32'(boot_done_o),  32'd0);
    chk("reset count", 32'(word_count_o), 32'd0);
    @(posedge clk); #2;
    fetch("load-phase fetch", 32'h0, NOP, 1'b0, 1'b0);

    beat(32'h00100093, 1'b0);
    beat(32'h00200113, 1'b0);
    beat(32'h002081B3, 1'b1);
    @(negedge clk);
    chk("boot done", 32'(boot_done_o), 32'd1);
    chk("count 3",   32'(word_count_o), 32'd3);
    chk("ready off", 32'(load_ready_o), 32'd0);
    @(posedge clk); #2;
    fetch("f0",    32'h0,   32'h00100093, 1'b0, 1'b0);
    fetch("f4",    32'h4,   32'h00200113, 1'b0, 1'b0);
    fetch("f8",    32'h8,   32'h002081B3, 1'b0, 1'b0);
    fetch("fC",    32'hC,   NOP, 1'b0, 1'b1);
    fetch("f100",  32'h100, NOP, 1'b0, 1'b1);
    fetch("f104",  32'h104, NOP, 1'b0, 1'b1);
    fetch("f6",    32'h6,   NOP, 1'b1, 1'b0);
    fetch("fE",    32'hE,   NOP, 1'b1, 1'b0);
    beat(32'hDEADBEEF, 1'b1);
    fetch("run ignores load", 32'h0, 32'h00100093, 1'b0, 1'b0);

    do_reset(1);
    for (int i = 0; i < DEPTH; i++) beat(32'h1000 + 32'(i), 1'b0);
    @(negedge clk);
    chk("full count", 32'(word_count_o), 32'd64);
    chk("full ready", 32'(load_ready_o), 32'd0);
    @(posedge clk); #2;
    beat(32'h00000BAD, 1'b0);
    fetch("full f0",   32'h0,   32'h1000, 1'b0, 1'b0);
    fetch("full fFC",  32'hFC,  32'h103F, 1'b0, 1'b0);
    fetch("full f100", 32'h100, NOP, 1'b0, 1'b1);

    do_reset(1);
    beat(32'hA0, 1'b0);
    beat(32'hA1, 1'b0);
    do_reset(1);
    beat(32'hB0, 1'b1);
    @(negedge clk);
    chk("reload count", 32'(word_count_o), 32'd1);
    @(posedge clk); #2;
    fetch("reload f0", 32'h0, 32'hB0, 1'b0, 1'b0);
    fetch("stale f4",  32'h4, NOP, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
